// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - memory command encoding (MEM field) seen by data_cache
//   - arbiter FSM state type
//   - is_write() helper: op 2'b11 is treated as a write
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   // The write bit dominates, so 2'b11 behaves as a write everywhere.
   function automatic logic is_write(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arb_if
// Bundles the two requester ports and the memory command port of the
// data-memory arbiter.
//   slave  : view taken by dmem_arbiter (takes requests, drives memory command)
//   master : view taken by the environment (requesters + memory)
// Signals:
//   rX_op/addr/wdata    requester X command (held until rX_done)
//   rX_done/err/rdata   requester X response (one-cycle pulse, rdata 0 otherwise)
//   mem_op/addr/wdata   command to data_cache (mem_op nonzero for one cycle)
//   mem_rdata/mem_ready response from data_cache
//   busy                arbiter not in IDLE
// -----------------------------------------------------------------------------
interface dmem_arb_if #(
   parameter int AW = 32
) ();

   logic [1:0]    r0_op;
   logic [AW-1:0] r0_addr;
   logic [31:0]   r0_wdata;
   logic          r0_done;
   logic          r0_err;
   logic [31:0]   r0_rdata;

   logic [1:0]    r1_op;
   logic [AW-1:0] r1_addr;
   logic [31:0]   r1_wdata;
   logic          r1_done;
   logic          r1_err;
   logic [31:0]   r1_rdata;

   logic [1:0]    mem_op;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_ready;

   logic          busy;

   modport slave (
      input  r0_op, r0_addr, r0_wdata,
      input  r1_op, r1_addr, r1_wdata,
      output r0_done, r0_err, r0_rdata,
      output r1_done, r1_err, r1_rdata,
      output mem_op, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      output busy
   );

   modport master (
      output r0_op, r0_addr, r0_wdata,
      output r1_op, r1_addr, r1_wdata,
      input  r0_done, r0_err, r0_rdata,
      input  r1_done, r1_err, r1_rdata,
      input  mem_op, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      input  busy
   );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-requester round-robin picker.
//   req[1:0] : request per port
//   last     : port granted most recently
//   gnt      : winning port index (meaningful only when any=1)
//   any      : at least one request present
// A lone requester always wins; on a tie the port that was not granted last
// wins, so back-to-back contention alternates.
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt,
   output logic       any
);

   assign any = |req;
   assign gnt = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data_cache command port between requester 0 (load/store
// unit) and requester 1 (debug/DMA loader). Round-robin grant, one-cycle
// command issue, completion tracking on mem_ready with a watchdog.
// Parameters:
//   TIMEOUT : WAIT cycles before the access is abandoned with err (>= 8)
//   AW      : address width (must match the interface AW)
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   bus     : dmem_arb_if.slave (requester ports + memory command port)
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int AW      = 32
) (
   input  logic        clk,
   input  logic        rst,
   dmem_arb_if.slave   bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t     state_q;
   logic           grant_q;
   logic           last_grant_q;
   logic [1:0]     op_q;
   logic [1:0]     mem_op_q;
   logic [AW-1:0]  addr_q;
   logic [31:0]    wdata_q;
   logic [CNT_W-1:0] cnt_q;

   logic           done0_q, done1_q;
   logic           err0_q, err1_q;
   logic [31:0]    rdata0_q, rdata1_q;

   logic [1:0]     req;
   logic           win;
   logic           any_req;

   assign req = {bus.r1_op != OP_NONE, bus.r0_op != OP_NONE};

   rr_arb2 u_rr_arb2 (
      .req  (req),
      .last (last_grant_q),
      .gnt  (win),
      .any  (any_req)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here sees the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         op_q         <= OP_NONE;
         mem_op_q     <= OP_NONE;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         // NOTE: response outputs default low every cycle; they are only
         // raised on the edge that enters RESP, which makes them one-cycle
         // pulses and keeps rdata at 0 outside done.
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;

         unique case (state_q)
            IDLE: begin
               // mem_ready gates the grant so an access still draining in the
               // memory (after reset or timeout) is never overrun.
               if (bus.mem_ready && any_req) begin
                  grant_q      <= win;
                  last_grant_q <= win;
                  op_q         <= win ? bus.r1_op    : bus.r0_op;
                  mem_op_q     <= win ? bus.r1_op    : bus.r0_op;
                  addr_q       <= win ? bus.r1_addr  : bus.r0_addr;
                  wdata_q      <= win ? bus.r1_wdata : bus.r0_wdata;
                  state_q      <= ISSUE;
               end
            end

            ISSUE: begin
               mem_op_q <= OP_NONE;
               cnt_q    <= '0;
               state_q  <= WAIT;
            end

            WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               // cnt_q == 0 marks the first WAIT cycle: mem_ready may still
               // reflect the idle memory, not a completion.
               if (cnt_q != '0 && bus.mem_ready) begin
                  state_q <= RESP;
                  if (grant_q) begin
                     done1_q  <= 1'b1;
                     rdata1_q <= is_write(op_q) ? 32'h0 : bus.mem_rdata;
                  end else begin
                     done0_q  <= 1'b1;
                     rdata0_q <= is_write(op_q) ? 32'h0 : bus.mem_rdata;
                  end
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  // Counter lands on TIMEOUT as RESP is entered.
                  state_q <= RESP;
                  if (grant_q) begin
                     done1_q <= 1'b1;
                     err1_q  <= 1'b1;
                  end else begin
                     done0_q <= 1'b1;
                     err0_q  <= 1'b1;
                  end
               end
            end

            RESP: begin
               addr_q  <= '0;
               wdata_q <= '0;
               state_q <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_op    = mem_op_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.r0_done   = done0_q;
   assign bus.r1_done   = done1_q;
   assign bus.r0_err    = err0_q;
   assign bus.r1_err    = err1_q;
   assign bus.r0_rdata  = rdata0_q;
   assign bus.r1_rdata  = rdata1_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the multi-cycle data memory (`data_cache`). It shares the single memory command port between requester 0 (pipeline load/store unit) and requester 1 (debug/DMA loader), using round-robin arbitration. It drives the memory's `MEM`/`Addr`/`Wdata` command handshake and tracks completion through the memory's ready/complete indication. Each transaction returns read data and a one-cycle `done` pulse, or an `err` pulse if a watchdog timeout expires.

## Interface
- `TIMEOUT`, 64: maximum WAIT cycles before a transaction is aborted with `err`; must be ≥ 8.
- `AW`, 32: address width.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `r0_op`, `r1_op` in 2: request op. bit1 = write, bit0 = read, 00 = none, 11 is treated as write.
- `r0_addr`, `r1_addr` in AW: request address.
- `r0_wdata`, `r1_wdata` in 32: write data.
- `r0_done`, `r1_done` out 1: one-cycle completion pulse.
- `r0_err`, `r1_err` out 1: one-cycle timeout pulse, coincident with `done`.
- `r0_rdata`, `r1_rdata` out 32: read data, valid only while `done`=1 for a read; 0 otherwise.
- `mem_op` out 2: memory command (MEM encoding). Nonzero only in the ISSUE state.
- `mem_addr` out AW: memory address, held from ISSUE until the return to IDLE.
- `mem_wdata` out 32: memory write data, held like `mem_addr`.
- `mem_rdata` in 32: memory read data, sampled only on completion of a read.
- `mem_ready` in 1: memory idle (when in its idle state) or completing the current access (read data valid or write committed).
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Moves to ISSUE only when `mem_ready`=1 and at least one `rX_op`≠0.
  - Winner selection: if only one port is requesting, it wins. If both are requesting, the port other than `last_grant` wins.
  - On the grant: register `grant`, set `last_grant` = winner, latch op/addr/wdata.
- **ISSUE (exactly 1 cycle):**
  - Drive `mem_op` = latched op.
  - Move to WAIT and clear the timeout counter.
- **WAIT:**
  - Ignore `mem_ready` in the first WAIT cycle, because the memory has just left idle.
  - From the second WAIT cycle on, `mem_ready`=1 means completion: capture `mem_rdata` if the op was a read, then move to RESP.
  - The counter increments every WAIT cycle. When it reaches TIMEOUT, move to RESP with the error flag set and captured data = 0.
- **RESP (1 cycle):**
  - Pulse `done` for the granted port only, with `err` if the error flag is set.
  - Present captured rdata on the granted port.
  - Ignore new requests; return to IDLE.
- **Requester rules:**
  - Hold op/addr/wdata stable until `done`.
  - Drop or change the request in the cycle after `done`.
  - The arbiter latches the request at grant, so later changes do not affect an in-flight access.
- **Reset values:**
  - State = IDLE, `last_grant` = 1 (port 0 wins the first tie).
  - Counter = 0, error flag = 0.
  - All outputs 0: `mem_op`=00, `done`/`err`=0, `rdata`=0, `busy`=0.
- **Reset mid-transaction:** abort immediately, no `done` is issued. After reset, IDLE waits for `mem_ready`=1 before issuing again, so any access still draining in the memory is respected.
- **Timeout with memory still running:** IDLE waits on `mem_ready` in the same way.

## Timing
Request first visible in IDLE at cycle N, with `mem_ready`=1:
- N+1: ISSUE, `mem_op` driven.
- **Read:** `mem_ready` rises at N+5; RESP/`done`/`rdata` at N+6. Total latency 6 cycles.
- **Write:** `mem_ready` rises at N+4; `done` at N+5. Total latency 5 cycles.
- Earliest next grant is at N+7 (read) or N+6 (write).
- Back-to-back competing requests alternate ports, so no port starves.
- All outputs are registered except `busy`, which is decoded from state.

## Structure
- Package `dmem_arb_pkg` holds:
  - `OP_NONE`=2'b00, `OP_READ`=2'b01, `OP_WRITE`=2'b10;
  - the state enum `arb_state_t` {IDLE, ISSUE, WAIT, RESP};
  - a helper `is_write(op)`, defined as `op[1]`.
- Sub-module `rr_arb2`: a combinational two-request round-robin picker. Inputs `req[1:0]` and `last`; outputs `gnt` and `any`.
- The FSM, the timeout counter and the latches stay in `dmem_arbiter`.

## Test plan
- **Single read:** `r0_op`=01, addr=0 at N.
  - Expect `mem_op`=01 at N+1 only.
  - Expect `r0_done`=1 and `r0_rdata`=32'h1 at N+6; `r1_done` stays 0.
- **Write then read:** r1 writes 32'hDEADBEEF to addr 5, then r1 reads addr 5.
  - Write: `r1_done` at N+5.
  - Read: returns 32'hDEADBEEF six cycles after its request.
- **Contention:** both ports request continuously, starting from reset.
  - Expect grants in order 0,1,0,1.
  - `mem_addr` alternates between the two ports' addresses.
- **Timeout:** memory model holds `mem_ready`=0 after issue.
  - Expect `done`=1, `err`=1 and `rdata`=0 exactly when the counter reaches TIMEOUT.
  - No new issue until `mem_ready` returns to 1.
- **Reset mid-read:** assert `rst` at N+3 of a read.
  - Expect no `done` pulse and all outputs 0 on the next cycle.
  - Next request is issued only after `mem_ready`=1.
- **Op 11 on r0:** expect `mem_op`=11 (write wins in memory) and write latency of 5 cycles.
